// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller for the EX stage.
// Owns HI/LO, a fixed-latency multiplier and a radix-2 restoring divider.
package muldiv_pkg;
  localparam logic [5:0] ALU_MULT  = 6'd24;
  localparam logic [5:0] ALU_MULTU = 6'd25;
  localparam logic [5:0] ALU_DIV   = 6'd26;
  localparam logic [5:0] ALU_DIVU  = 6'd27;
  localparam logic [5:0] ALU_MTHI  = 6'd28;
  localparam logic [5:0] ALU_MTLO  = 6'd29;
endpackage

module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [5:0]  alu_ctrl,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        pipe_stall,
  output logic        stall,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] rem;
  logic        sgn;
  logic        q_neg;
  logic        r_neg;

  logic        is_mul;
  logic        is_div;
  logic        is_mthi;
  logic        is_mtlo;
  logic        accept;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] rem_nx;
  logic [31:0] q_nx;
  logic [63:0] prod;

  assign is_mul  = (alu_ctrl == ALU_MULT) || (alu_ctrl == ALU_MULTU);
  assign is_div  = (alu_ctrl == ALU_DIV) || (alu_ctrl == ALU_DIVU);
  assign is_mthi = (alu_ctrl == ALU_MTHI);
  assign is_mtlo = (alu_ctrl == ALU_MTLO);
  assign accept  = (state == IDLE) && start && !flush;

  assign a_neg = (alu_ctrl == ALU_DIV) && src_a[31];
  assign b_neg = (alu_ctrl == ALU_DIV) && src_b[31];
  assign abs_a = a_neg ? -src_a : src_a;
  assign abs_b = b_neg ? -src_b : src_b;

  // op_a doubles as the quotient shift register while dividing
  assign rem_sh = {rem, op_a[31]};
  assign ge     = rem_sh >= {1'b0, op_b};
  assign diff   = rem_sh - {1'b0, op_b};
  assign rem_nx = ge ? diff[31:0] : rem_sh[31:0];
  assign q_nx   = {op_a[30:0], ge};

  assign prod = {{32{sgn & op_a[31]}}, op_a} *
                {{32{sgn & op_b[31]}}, op_b};

  assign busy = (state != IDLE);

  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:    stall = accept && (is_mul || is_div);
      MUL,
      DIV:     stall = !flush;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      rem   <= '0;
      sgn   <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_mul: begin
                op_a  <= src_a;
                op_b  <= src_b;
                sgn   <= (alu_ctrl == ALU_MULT);
                cnt   <= MUL_CNT;
                state <= MUL;
              end
              is_div: begin
                op_a  <= abs_a;
                op_b  <= abs_b;
                rem   <= '0;
                q_neg <= a_neg ^ b_neg;
                r_neg <= a_neg;
                cnt   <= 5'd31;
                state <= DIV;
              end
              is_mthi: hi_o <= src_a;
              is_mtlo: lo_o <= src_a;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            {hi_o, lo_o} <= prod;
            state <= DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            op_a <= q_nx;
            rem  <= rem_nx;
            if (cnt == '0) begin
              lo_o  <= q_neg ? -q_nx : q_nx;
              hi_o  <= r_neg ? -rem_nx : rem_nx;
              state <= DONE;
            end else begin
              cnt <= cnt - 5'd1;
            end
          end
        end
        DONE: begin
          // the instruction leaves EX once the pipeline moves
          if (flush || !pipe_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: driver pushes model results,
// a negedge monitor pops and compares when a stall window closes.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [5:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        pipe_stall;
  logic        stall;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .alu_ctrl   (alu_ctrl),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .pipe_stall (pipe_stall),
    .stall      (stall),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          abort    = 1'b0;
  int          scnt     = 0;
  logic [31:0] hi_m     = '0;
  logic [31:0] lo_m     = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic on magnitudes, then sign rules
  task automatic model(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    longint      ma, mb, q, r;
    bit          an, bn;
    if (op == ALU_MULT) begin
      p = 64'(longint'($signed(a)) * longint'($signed(b)));
      {eh, el} = p;
    end else if (op == ALU_MULTU) begin
      p = {32'b0, a} * {32'b0, b};
      {eh, el} = p;
    end else begin
      an = (op == ALU_DIV) && a[31];
      bn = (op == ALU_DIV) && b[31];
      ma = an ? -longint'($signed(a)) : longint'({32'b0, a});
      mb = bn ? -longint'($signed(b)) : longint'({32'b0, b});
      if (mb == 0) begin
        q = 64'h0000_0000_FFFF_FFFF;
        r = ma;
      end else begin
        q = ma / mb;
        r = ma % mb;
      end
      if (an ^ bn) q = -q;
      if (an) r = -r;
      el = q[31:0];
      eh = r[31:0];
    end
  endtask

  task automatic issue(logic [5:0] op, logic [31:0] a, logic [31:0] b,
                       int ps);
    logic [31:0] eh, el;
    exp_t        e;
    int          budget;
    model(op, a, b, eh, el);
    e.hi  = eh;
    e.lo  = el;
    e.lat = (op == ALU_MULT || op == ALU_MULTU) ? 1 + MUL_LAT : 33;
    sb.push_back(e);
    hi_m = eh;
    lo_m = el;
    start    = 1'b1;
    alu_ctrl = op;
    src_a    = a;
    src_b    = b;
    budget   = 0;
    do begin
      @(posedge clk);
      #1;
      budget++;
    end while (stall && budget < 100);
    if (budget >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL op_timeout: stall=%0b after %0d cycles, expected 0",
               stall, budget);
    end
    chk("done_busy", 64'(busy), 64'd1);
    chk("done_stall", 64'(stall), 64'd0);
    for (int i = 0; i < ps; i++) begin
      pipe_stall = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_busy", 64'(busy), 64'd1);
      chk("hold_hilo", {hi_o, lo_o}, {eh, el});
    end
    pipe_stall = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_done", 64'(busy), 64'd0);
    start = 1'b0;
  endtask

  task automatic mt(bit to_hi, logic [31:0] v);
    start    = 1'b1;
    alu_ctrl = to_hi ? ALU_MTHI : ALU_MTLO;
    src_a    = v;
    #1;
    chk("mt_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (to_hi) hi_m = v;
    else lo_m = v;
    chk("mt_hilo", {hi_o, lo_o}, {hi_m, lo_m});
    chk("mt_busy", 64'(busy), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!resetn || abort) begin
      scnt = 0;
    end else if (stall) begin
      scnt++;
    end else if (scnt > 0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: commit seen, expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_hilo", {hi_o, lo_o}, {e.hi, e.lo});
        chk("mon_stall_len", 64'(scnt), 64'(e.lat));
      end
      scnt = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  ops[4];
    logic [31:0] a, b;
    int          r;
    ops[0] = ALU_MULT;
    ops[1] = ALU_MULTU;
    ops[2] = ALU_DIV;
    ops[3] = ALU_DIVU;

    resetn     = 1'b0;
    start      = 1'b0;
    alu_ctrl   = '0;
    src_a      = '0;
    src_b      = '0;
    flush      = 1'b0;
    pipe_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    issue(ALU_MULT, 32'hFFFF_FFFD, 32'd5, 0);
    chk("mult_neg", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(ALU_DIVU, 32'd100, 32'd7, 0);
    chk("divu_100_7", {hi_o, lo_o}, {32'd2, 32'd14});
    issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_neg", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf", {hi_o, lo_o}, {32'd0, 32'h8000_0000});
    issue(ALU_DIVU, 32'h1234, 32'd0, 0);
    chk("divu_zero", {hi_o, lo_o}, {32'h1234, 32'hFFFF_FFFF});
    issue(ALU_DIV, 32'hFFFF_FF00, 32'd0, 1);

    mt(1'b1, 32'hAAAA_0000);
    mt(1'b0, 32'h0000_5555);

    abort    = 1'b1;
    start    = 1'b1;
    alu_ctrl = ALU_DIV;
    src_a    = $urandom;
    src_b    = 32'd3;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    #1;
    chk("flush_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    chk("flush_idle", 64'(busy), 64'd0);
    chk("flush_hilo", {hi_o, lo_o}, {32'hAAAA_0000, 32'h0000_5555});
    abort = 1'b0;

    issue(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
    chk("multu_max", {hi_o, lo_o}, {32'hFFFF_FFFE, 32'd1});
    mt(1'b0, 32'h1234_5678);

    abort    = 1'b1;
    start    = 1'b1;
    alu_ctrl = ALU_DIV;
    src_a    = 32'd1000;
    src_b    = 32'd3;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    resetn = 1'b0;
    start  = 1'b0;
    #1;
    chk("mid_rst_stall", 64'(stall), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_hilo", {hi_o, lo_o}, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    abort  = 1'b0;
    hi_m   = '0;
    lo_m   = '0;
    issue(ALU_MULT, 32'd7, 32'd6, 0);
    chk("mult_7_6", {hi_o, lo_o}, 64'd42);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        mt(1'($urandom_range(0, 1)), $urandom);
      end
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 500));
      r = $urandom_range(0, 9);
      if (r == 0) b = '0;
      else if (r <= 3) b = 32'($urandom_range(1, 20));
      else if (r == 4) b = 32'hFFFF_FFFF;
      else b = $urandom;
      issue(ops[$urandom_range(0, 3)], a, b, $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle HI/LO unit controller for the EX stage.
- Accepts `ALU_MULT`/`ALU_MULTU`/`ALU_DIV`/`ALU_DIVU`/`ALU_MTHI`/`ALU_MTLO` codes from alu_decoder (aludefines.vh encodings).
- Owns the HI/LO registers and contains an iterative one-bit-per-cycle divider and a fixed-latency multiplier.
- Drives a stall to the hazard unit while an operation is in flight. It also handles flush and external pipeline stall, so each instruction commits exactly once.

Parameters:
- MUL_LAT, 2, compute cycles for multiply after the acceptance cycle (legal range 1..8).

Ports:
- clk  in  1  clock; everything rising-edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  EX-stage instruction valid.
- alu_ctrl  in  6  ALUControl of the EX instruction.
- src_a  in  32  rs operand (dividend/multiplicand/MTHI/MTLO data).
- src_b  in  32  rt operand (divisor/multiplier).
- flush  in  1  exception flush of EX stage.
- pipe_stall  in  1  pipeline held by another stall source.
- stall  out  1  hold pipeline, muldiv busy.
- hi_o  out  32  HI register.
- lo_o  out  32  LO register.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE, hi_o=0, lo_o=0, stall=0, busy=0. All internal operands and counters are cleared.
- Reset mid-operation aborts immediately, with no HI/LO write.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1, flush=0, alu_ctrl is MULT/MULTU:
  - stall=1 combinationally.
  - Latch operands and signedness.
  - Go to MUL with counter=MUL_LAT-1.
- IDLE, start=1, flush=0, alu_ctrl is DIV/DIVU:
  - stall=1 combinationally.
  - Latch absolute values (DIV) or raw values (DIVU), plus the quotient and remainder sign flags.
  - Go to DIV with counter=31.
- IDLE, start=1, flush=0, alu_ctrl is MTHI/MTLO:
  - HI (or LO) <= src_a at the edge.
  - stall=0; state stays IDLE. A repeated write while pipe_stall=1 is harmless.
- IDLE, any other case: no action, stall=0.
- MUL:
  - stall=1, counter decrements each cycle.
  - At counter=0: HI:LO <= 64-bit product, signed for MULT and unsigned for MULTU; go to DONE.
  - Stall is high for 1+MUL_LAT cycles.
- DIV:
  - stall=1. Restoring division, one quotient bit per cycle, MSB first, 32 iterations.
  - On the last iteration: LO <= quotient and HI <= remainder, sign-fixed.
  - Quotient is negated if the operand signs differ. Remainder takes the dividend's sign (truncation toward zero).
  - Go to DONE. Stall is high for 33 cycles.
- Divide by zero:
  - No trap. The magnitude algorithm yields quotient=0xFFFFFFFF and remainder=dividend magnitude, then the sign fix applies.
  - DIVU x/0 gives LO=0xFFFFFFFF, HI=x.
- DONE:
  - stall=0, HI/LO already committed; start is ignored, because the same instruction is still in EX.
  - Stay while pipe_stall=1. Go to IDLE when pipe_stall=0, since the instruction leaves EX at that edge.
- flush=1 in MUL or DIV: return to IDLE at the next edge with no HI/LO write; stall is combinationally 0 during the flush cycle.
- flush=1 in IDLE: start is ignored.
- flush=1 in DONE: go to IDLE. HI/LO stay committed.
- pipe_stall does not pause MUL/DIV computation.
- Back-to-back muldiv: the second instruction is accepted in the first IDLE cycle after DONE.
- MFHI/MFLO read hi_o/lo_o directly. A value written at an edge is visible to the instruction in EX the next cycle.
- Width rules:
  - Product is full 64 bits.
  - Divider partial remainder is 33 bits.
  - Negation of 0x80000000 wraps: DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.

Test Plan:
- MULT src_a=0xFFFFFFFD, src_b=5, MUL_LAT=2 -> stall high 3 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; DONE for 1 cycle, then IDLE.
- DIVU 100/7 -> stall high exactly 33 cycles, LO=14, HI=2. DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x1234, no hang.
- Preload HI=0xAAAA0000, LO=0x5555; flush on the 10th DIV cycle -> stall low that cycle, IDLE next, HI/LO unchanged.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with pipe_stall=1 for 3 cycles after DONE -> HI=0xFFFFFFFE, LO=1 written once, no restart, IDLE after pipe_stall drops. Then MTLO 0x12345678 -> LO updated next cycle with zero stall cycles.
- resetn low mid-DIV, then high -> IDLE, stall=0, HI=LO=0. A new MULT 7*6 completes with LO=42, HI=0.
